ecc_secded_dec_pipe: RTL and testbench



---
 rtl/ecc_secded_dec_pipe.sv | 167 ++++++++++++++++
 tb/tb_ecc_secded_dec_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_secded_dec_pipe.sv
// Two-stage pipelined SECDED (extended Hamming) decoder with valid/ready flow control and error counters.
// Optional first-error log enabled by defining ECC_ERR_LOG_EN.
module ecc_secded_dec_pipe #(
  parameter int unsigned DW    = 64,
  parameter int unsigned KW    = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW+KW-1:0]    in_cw,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic                out_sgl,
  output logic                out_dbl,
  output logic [KW-1:0]       out_syn,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    sgl_cnt,
  output logic [CNT_W-1:0]    dbl_cnt
`ifdef ECC_ERR_LOG_EN
  ,
  output logic                log_valid,
  output logic [KW-1:0]       log_syn,
  output logic [CNT_W-1:0]    log_idx
`endif
);

  localparam int unsigned CW   = DW + KW;
  localparam int unsigned SW   = KW - 1;
  localparam int unsigned NPOS = CW - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Hamming position of each data bit: non-power-of-two positions in ascending order.
  function automatic logic [DW-1:0][SW-1:0] build_dpos();
    logic [DW-1:0][SW-1:0] t;
    int unsigned n;
    t = '0;
    n = 0;
    for (int unsigned p = 3; p <= NPOS; p++) begin
      if (((p & (p - 1)) != 0) && (n < DW)) begin
        t[n] = SW'(p);
        n++;
      end
    end
    return t;
  endfunction

  localparam logic [DW-1:0][SW-1:0] DPOS = build_dpos();

  logic            advance;
  logic            fire;
  logic [SW-1:0]   syn_c;
  logic            s1_valid;
  logic [SW-1:0]   s1_syn;
  logic            s1_p;
  logic [DW-1:0]   s1_data;
  logic [DW-1:0]   dec_data;
  logic            dec_sgl;
  logic            dec_dbl;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign fire     = out_valid && out_ready;

  // Syndrome is the XOR of the positions of all set bits; check ci sits at position 2^i.
  always_comb begin
    syn_c = '0;
    for (int unsigned d = 0; d < DW; d++) begin
      if (in_cw[d]) syn_c = syn_c ^ DPOS[d];
    end
    for (int unsigned i = 0; i < SW; i++) begin
      syn_c[i] = syn_c[i] ^ in_cw[DW+i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_syn   <= '0;
      s1_p     <= 1'b0;
      s1_data  <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_syn  <= syn_c;
        s1_p    <= ^in_cw;
        s1_data <= in_cw[DW-1:0];
      end
    end
  end

  // Syndromes of zero or a power of two match no data position, so data passes unchanged.
  always_comb begin
    dec_data = s1_data;
    dec_sgl  = 1'b0;
    dec_dbl  = 1'b0;
    if (s1_p) begin
      if (s1_syn > SW'(NPOS)) begin
        dec_dbl = 1'b1;
      end else begin
        dec_sgl = 1'b1;
        for (int unsigned d = 0; d < DW; d++) begin
          if (s1_syn == DPOS[d]) dec_data[d] = ~dec_data[d];
        end
      end
    end else if (s1_syn != '0) begin
      dec_dbl = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sgl   <= 1'b0;
      out_dbl   <= 1'b0;
      out_syn   <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= dec_data;
        out_sgl  <= dec_sgl;
        out_dbl  <= dec_dbl;
        out_syn  <= {s1_p, s1_syn};
      end
    end
  end

  // Saturating error counters; clear wins over a same-cycle count event.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sgl_cnt <= '0;
      dbl_cnt <= '0;
    end else if (fire) begin
      if (out_sgl && (sgl_cnt != CNT_MAX)) sgl_cnt <= sgl_cnt + CNT_W'(1);
      if (out_dbl && (dbl_cnt != CNT_MAX)) dbl_cnt <= dbl_cnt + CNT_W'(1);
    end
  end

`ifdef ECC_ERR_LOG_EN
  logic [CNT_W-1:0] hs_cnt;

  // First error since reset or clear is captured with the handshake index it occurred on.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_cnt    <= '0;
      log_valid <= 1'b0;
      log_syn   <= '0;
      log_idx   <= '0;
    end else begin
      if (fire) hs_cnt <= hs_cnt + CNT_W'(1);
      if (cnt_clr) begin
        log_valid <= 1'b0;
        log_syn   <= '0;
        log_idx   <= '0;
      end else if (fire && (out_sgl || out_dbl) && !log_valid) begin
        log_valid <= 1'b1;
        log_syn   <= out_syn;
        log_idx   <= hs_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ecc_secded_dec_pipe.sv
// Randomized self-checking bench for ecc_secded_dec_pipe; expectations come from the injected error pattern.
module tb_ecc_secded_dec_pipe;

  localparam int DW    = 64;
  localparam int KW    = 8;
  localparam int SW    = KW - 1;
  localparam int CW    = DW + KW;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct {
    logic [DW-1:0] data;
    logic          sgl;
    logic          dbl;
    logic [KW-1:0] syn;
    int            cyc;
    bit            lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CW-1:0]    in_cw = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    out_data;
  logic             out_sgl;
  logic             out_dbl;
  logic [KW-1:0]    out_syn;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] sgl_cnt;
  logic [CNT_W-1:0] dbl_cnt;
`ifdef ECC_ERR_LOG_EN
  logic             log_valid;
  logic [KW-1:0]    log_syn;
  logic [CNT_W-1:0] log_idx;
`endif

  ecc_secded_dec_pipe #(.DW(DW), .KW(KW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sgl(out_sgl), .out_dbl(out_dbl), .out_syn(out_syn),
    .cnt_clr(cnt_clr), .sgl_cnt(sgl_cnt), .dbl_cnt(dbl_cnt)
`ifdef ECC_ERR_LOG_EN
    , .log_valid(log_valid), .log_syn(log_syn), .log_idx(log_idx)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  exp_t cur_exp;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Hamming position of codeword bit j (overall parity counts as position 0).
  function automatic int pos_of(input int j);
    int n = -1;
    if (j == CW - 1) return 0;
    if (j >= DW) return 1 << (j - DW);
    for (int p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        n++;
        if (n == j) return p;
      end
    end
    return -1;
  endfunction

  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] cw;
    int s = 0;
    cw = '0;
    cw[DW-1:0] = d;
    for (int j = 0; j < DW; j++) if (d[j]) s = s ^ pos_of(j);
    for (int i = 0; i < SW; i++) cw[DW+i] = s[i];
    cw[CW-1] = ^cw[CW-2:0];
    return cw;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic send(input logic [CW-1:0] cw, input exp_t e);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_cw    = cw;
    cur_exp  = e;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) check("send_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  // nf flips: 0 clean, 1 single at j1, 2 double at j1 and j2.
  task automatic send_word(input logic [DW-1:0] d, input int nf, input int j1, input int j2);
    logic [CW-1:0] cw;
    exp_t e;
    cw = encode(d);
    if (nf >= 1) cw[j1] = ~cw[j1];
    if (nf == 2) cw[j2] = ~cw[j2];
    e.data = d;
    e.sgl  = 1'b0;
    e.dbl  = 1'b0;
    e.syn  = '0;
    e.cyc  = 0;
    e.lat  = (rdy_mode == 0);
    if (nf == 1) begin
      e.sgl = 1'b1;
      e.syn = {1'b1, SW'(pos_of(j1))};
    end
    if (nf == 2) begin
      e.dbl  = 1'b1;
      e.data = cw[DW-1:0];
      e.syn  = {1'b0, SW'(pos_of(j1) ^ pos_of(j2))};
    end
    send(cw, e);
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 0;
    while (q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
    tick();
    tick();
  endtask

  // Monitor: scoreboard, counter model and stall stability, all sampled mid-cycle.
  logic [CNT_W-1:0] m_sgl = '0;
  logic [CNT_W-1:0] m_dbl = '0;
  bit               rst_was = 1'b0;
  bit               prev_stall = 1'b0;
  logic [DW-1:0]    p_data;
  logic [KW-1:0]    p_syn;
  logic [1:0]       p_flags;
  exp_t             e_out;
  exp_t             e_in;

  always @(negedge clk) begin
    if (rst) begin
      if (rst_was) begin
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_flags", 64'({out_sgl, out_dbl}), 64'd0);
        check("rst_out_syn", 64'(out_syn), 64'd0);
        check("rst_sgl_cnt", 64'(sgl_cnt), 64'd0);
        check("rst_dbl_cnt", 64'(dbl_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
      end
      q.delete();
      m_sgl = '0;
      m_dbl = '0;
      prev_stall = 1'b0;
    end else begin
      check("sgl_cnt", 64'(sgl_cnt), 64'(m_sgl));
      check("dbl_cnt", 64'(dbl_cnt), 64'(m_dbl));
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(p_data));
        check("stall_syn", 64'(out_syn), 64'(p_syn));
        check("stall_flags", 64'({out_sgl, out_dbl}), 64'(p_flags));
      end
      if (out_valid && out_ready) begin
        check("out_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e_out = q.pop_front();
          check("out_data", 64'(out_data), 64'(e_out.data));
          check("out_flags", 64'({out_sgl, out_dbl}), 64'({e_out.sgl, e_out.dbl}));
          check("out_syn", 64'(out_syn), 64'(e_out.syn));
          if (e_out.lat) check("latency", 64'(cyc - e_out.cyc), 64'd2);
          if (!cnt_clr) begin
            if (e_out.sgl && m_sgl != CNT_MAX) m_sgl = m_sgl + 1'b1;
            if (e_out.dbl && m_dbl != CNT_MAX) m_dbl = m_dbl + 1'b1;
          end
        end
      end
      if (cnt_clr) begin
        m_sgl = '0;
        m_dbl = '0;
      end
      if (in_valid && in_ready) begin
        e_in = cur_exp;
        e_in.cyc = cyc;
        q.push_back(e_in);
      end
      prev_stall = out_valid && !out_ready;
      p_data  = out_data;
      p_syn   = out_syn;
      p_flags = {out_sgl, out_dbl};
    end
    rst_was = rst;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    int j1;
    int j5;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Clean stream at full throughput.
    rdy_mode = 0;
    for (int i = 0; i < 1000; i++) send_word(rand_word(), 0, 0, 0);
    drain();

    // Directed single/double errors on a fixed word.
    d = 64'h0123_4567_89AB_CDEF;
    send_word(d, 1, 0, 0);
    drain();
    check("dir_sgl_cnt_1", 64'(sgl_cnt), 64'd1);
    send_word(d, 1, CW - 1, 0);
    send_word(d, 1, DW + 3, 0);
    send_word(d, 2, 5, 40);
    drain();
    check("dir_sgl_cnt_3", 64'(sgl_cnt), 64'd3);
    check("dir_dbl_cnt_1", 64'(dbl_cnt), 64'd1);

    // Mixed errors with random back-pressure and bubbles.
    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      j1 = $urandom_range(0, CW - 1);
      send_word(rand_word(), $urandom_range(0, 2), j1, (j1 + $urandom_range(1, CW - 1)) % CW);
    end
    drain();

    // Saturate the single-error counter.
    for (int i = 0; i < 300; i++) send_word(rand_word(), 1, $urandom_range(0, CW - 1), 0);
    drain();
    check("sgl_saturated", 64'(sgl_cnt), 64'(CNT_MAX));

    // Clear coinciding with an error handshake.
    cnt_clr = 1'b1;
    send_word(rand_word(), 1, $urandom_range(0, CW - 1), 0);
    tick();
    tick();
    cnt_clr = 1'b0;
    drain();
    check("clr_sgl_cnt", 64'(sgl_cnt), 64'd0);
    check("clr_dbl_cnt", 64'(dbl_cnt), 64'd0);

    // Reset with both stages full and the output stalled.
    rdy_mode = 2;
    tick();
    cur_exp.data = '0; cur_exp.sgl = 1'b0; cur_exp.dbl = 1'b0;
    cur_exp.syn = '0; cur_exp.cyc = 0; cur_exp.lat = 1'b0;
    in_valid = 1'b1;
    in_cw = encode(rand_word());
    repeat (3) tick();
    check("fill_stalled", 64'({out_valid, in_ready}), 64'b10);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rdy_mode = 0;
    out_ready = 1'b1;
    rst = 1'b0;

    // Errors on handshakes 5 and 9 after reset; first send is accepted on the first edge out of reset.
    j5 = $urandom_range(0, DW - 1);
    for (int i = 0; i < 12; i++) begin
      if (i == 5) send_word(rand_word(), 1, j5, 0);
      else if (i == 9) send_word(rand_word(), 1, $urandom_range(0, CW - 1), 0);
      else send_word(rand_word(), 0, 0, 0);
    end
    drain();
    check("post_rst_sgl_cnt", 64'(sgl_cnt), 64'd2);
`ifdef ECC_ERR_LOG_EN
    check("log_valid", 64'(log_valid), 64'd1);
    check("log_idx", 64'(log_idx), 64'd5);
    check("log_syn", 64'(log_syn), 64'({1'b1, SW'(pos_of(j5))}));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
